// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: valid/ready command FIFO feeding the ALU with a registered issue strobe.
// Define ALU_CMDQ_DIVZERO_DROP_EN to discard divide-by-zero commands and count them in drop_cnt.
module alu_cmd_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_a,
   input  logic [DATA_W-1:0]         in_b,
   input  logic [2:0]                in_op,
   input  logic                      in_cin,
   input  logic                      stall,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   output logic [2:0]                alu_op,
   output logic                      alu_cin,
   output logic                      issue_valid,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow_err,
   output logic [7:0]                drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 2 * DATA_W + 4;

   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_hs, w_push, w_pop;

   assign in_ready = r_count < CW'(DEPTH);
   assign w_hs     = in_valid && in_ready;
   assign w_pop    = (r_count != '0) && !stall;
   assign count    = r_count;

`ifdef ALU_CMDQ_DIVZERO_DROP_EN
   logic       w_divz;
   logic [7:0] r_drop;
   // Dropped commands still complete the handshake; they just never reach storage.
   assign w_divz   = w_hs && (in_op == 3'b110) && (in_b == '0);
   assign w_push   = w_hs && !w_divz;
   assign drop_cnt = r_drop;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_drop <= '0;
      else if (w_divz && r_drop != 8'hff) r_drop <= r_drop + 8'd1;
`else
   assign w_push   = w_hs;
   assign drop_cnt = '0;
`endif

   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr_ptr] <= {in_a, in_b, in_op, in_cin};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= '0;
         alu_cin      <= 1'b0;
         issue_valid  <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            {alu_a, alu_b, alu_op, alu_cin} <= r_mem[r_rd_ptr];
         end
         r_count     <= r_count + CW'(w_push) - CW'(w_pop);
         issue_valid <= w_pop;
         if (in_valid && !in_ready) overflow_err <= 1'b1;
      end
endmodule

// File: doc/alu_cmd_queue.md
# alu_cmd_queue

Command queue sitting directly upstream of the 8-bit ALU. Accepts operand/opcode tuples (a, b, alu_op, cin) over a valid/ready handshake, buffers them in a small FIFO, and issues one command per clock into the ALU's input ports with a registered issue strobe. The ALU then produces its 16-bit result on the following rising edge. Optional filtering removes divide-by-zero commands before they reach the ALU.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- DATA_W, 8, operand width, signed two's complement
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low
- in_valid  in  1  upstream command present
- in_ready  out  1  queue can accept; equals (count < DEPTH)
- in_a  in  DATA_W  operand a, signed
- in_b  in  DATA_W  operand b, signed
- in_op  in  3  ALU opcode: 000 add, 001 sub, 101 mul, 110 div; other codes passed through unchanged
- in_cin  in  1  carry-in
- stall  in  1  downstream hold; no issue while high
- alu_a  out  DATA_W  registered operand a to ALU
- alu_b  out  DATA_W  registered operand b to ALU
- alu_op  out  3  registered opcode to ALU
- alu_cin  out  1  registered carry-in to ALU
- issue_valid  out  1  high for exactly the cycle after a pop edge; marks alu_* as a new command
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow_err  out  1  sticky; set when in_valid is high while in_ready is low
- drop_cnt  out  8  dropped divide-by-zero commands; saturates at 255

## Operation
- Push: at a rising edge where in_valid && in_ready, the tuple is written at wr_ptr and wr_ptr increments (modulo DEPTH).
- Pop: at a rising edge where count != 0 && !stall, the head entry is loaded into alu_* and rd_ptr increments (modulo DEPTH). issue_valid is 1 after that edge and 0 otherwise.
- When no pop occurs, alu_* hold their last values.
- Simultaneous push and pop: both take effect and count is unchanged.
- No empty bypass. A command accepted into an empty queue is not popped on the same edge.
- Full: in_ready = 0. An in_valid held against a full queue is not written and sets overflow_err, which clears only on reset.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty is decided from count, never from pointer equality.
- Width rules:
  - Operands are stored bit-exact; no sign extension.
  - ALU result width (16) is not this block's concern.
- Reset (asserted at any time, including mid-stream):
  - count = 0, both pointers = 0
  - alu_a/alu_b/alu_op/alu_cin = 0, issue_valid = 0
  - overflow_err = 0, drop_cnt = 0
  - All queued commands are discarded. in_ready = 1 while in reset.

## Timing
- Accept-to-issue latency with an empty queue and stall low:
  - Edge N: accept.
  - Edge N+1: pop; alu_* and issue_valid valid during cycle N+1..N+2.
  - Edge N+2: ALU registers the result.
- Sustained throughput: one command per clock when stall is low.
- stall is sampled at the edge. Raising stall blocks the pop at that same edge. The entry already issued is unaffected.
- in_ready and count are registered-derived: no combinational path from in_valid to in_ready.
- Reset deassertion is synchronous to clk externally. The first push can occur on the first edge after rst_n rises.

## Configuration
- ALU_CMDQ_DIVZERO_DROP_EN
  - Defined: a handshaked command with in_op == 110 and in_b == 0 completes the handshake under normal in_ready rules, but is not written. count does not increment and drop_cnt increments, saturating at 255. A simultaneous pop still proceeds.
  - Undefined: such commands are queued and issued like any other, and drop_cnt is tied to 0.

## Test plan
- Reset/idle: hold rst_n low 3 cycles → count = 0, in_ready = 1, issue_valid = 0, alu_* = 0; release and check no issue occurs with in_valid low.
- Single command: push a = −5, b = 3, op = 000 into an empty queue at edge N → issue_valid high after N+1 with alu_a = −5, alu_b = 3; ALU result = −2 after N+2.
- Fill and overflow (DEPTH = 4): stall = 1, push 4 commands → count = 4, in_ready = 0. A 5th in_valid sets overflow_err = 1 and count stays 4. Release stall → 4 consecutive issue_valid pulses in FIFO order, then count = 0.
- Simultaneous push/pop with wrap: stream 10 back-to-back commands with stall low → count stays 1, pointers wrap twice, and every command is issued exactly once and in order.
- Divide-by-zero with macro defined: push op = 110, a = −9, b = 0, then op = 110, a = −9, b = 3 → only the second issues; drop_cnt = 1. With the macro undefined, both issue and drop_cnt = 0.
- Mid-stream reset: with 3 entries queued and stall = 1, pulse rst_n low for 1 cycle → count = 0, and no issue_valid after stall is released.
